relu_pool_ctrl: RTL and testbench

Sequencing controller for the ReLU + 2x2 max-pool stage that follows the convolution layer. It tracks the raster position of each 3-channel conv output beat and issues the aligned control strobes that the per-channel datapath needs: hold-register load, line-buffer write and read address, and pooled-output emit. It also handles frame start, frame completion and the detection of stray beats. The block contains no data path; the channel values never pass through it.

---
 rtl/relu_pool_if.sv | 34 +++
 rtl/relu_pool_ctrl.sv | 134 +++++++++++++
 tb/tb_relu_pool_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/relu_pool_if.sv
// Handshake and strobe bundle between the conv output sequencer and the
// ReLU + 2x2 max-pool datapath. The master side issues start and beats,
// the slave side (the controller) returns the aligned control strobes.
interface relu_pool_if #(
   parameter int IN_W = 24,
   parameter int IN_H = 24
);
   localparam int PW = (IN_W / 2 > 1) ? $clog2(IN_W / 2) : 1;
   localparam int PH = (IN_H / 2 > 1) ? $clog2(IN_H / 2) : 1;

   logic          start;
   logic          valid_in;
   logic          busy;
   logic          hold_en;
   logic          lb_wr_en;
   logic          out_en;
   logic [PW-1:0] lb_addr;
   logic [PH-1:0] out_row;
   logic [PW-1:0] out_col;
   logic          frame_done;
   logic          drop_err;

   modport master (
      output start, valid_in,
      input  busy, hold_en, lb_wr_en, out_en, lb_addr, out_row, out_col,
             frame_done, drop_err
   );

   modport slave (
      input  start, valid_in,
      output busy, hold_en, lb_wr_en, out_en, lb_addr, out_row, out_col,
             frame_done, drop_err
   );
endinterface

// File: rtl/relu_pool_ctrl.sv
// Sequencing controller for the ReLU + 2x2 max-pool stage. Tracks the raster
// position of each conv beat and issues registered hold / line-buffer /
// emit strobes, one cycle after the beat, to line up with the registered
// ReLU result. No channel data passes through this block.
module relu_pool_ctrl #(
   parameter int CONV_BIT = 12,
   parameter int IN_W     = 24,
   parameter int IN_H     = 24
) (
   input  logic      clk,
   input  logic      rst,
   relu_pool_if.slave bus
);
   localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
   localparam int PW = (IN_W / 2 > 1) ? $clog2(IN_W / 2) : 1;
   localparam int PH = (IN_H / 2 > 1) ? $clog2(IN_H / 2) : 1;

   localparam logic [CW-1:0] LAST_COL = CW'(IN_W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IN_H - 1);

   // Reject geometries the 2x2 pooling walk cannot handle.
   if (IN_W < 2 || (IN_W % 2) != 0 || IN_H < 2 || (IN_H % 2) != 0 || CONV_BIT < 1)
   begin : g_bad_param
      $error("relu_pool_ctrl: IN_W/IN_H must be even and >= 2, CONV_BIT >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          r_busy;
   logic          r_hold_en;
   logic          r_lb_wr_en;
   logic          r_out_en;
   logic [PW-1:0] r_lb_addr;
   logic [PH-1:0] r_out_row;
   logic [PW-1:0] r_out_col;
   logic          r_frame_done;
   logic          r_drop_err;

   // Pooled column / row of the current beat: each 2x2 window covers two
   // raster columns and two raster rows.
   logic [PW-1:0] w_pair_col;
   logic [PH-1:0] w_pair_row;
   assign w_pair_col = PW'(r_col >> 1);
   assign w_pair_row = PH'(r_row >> 1);

   // Frame FSM: position tracking, strobe decode and error/status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_col        <= '0;
         r_row        <= '0;
         r_busy       <= 1'b0;
         r_hold_en    <= 1'b0;
         r_lb_wr_en   <= 1'b0;
         r_out_en     <= 1'b0;
         r_lb_addr    <= '0;
         r_out_row    <= '0;
         r_out_col    <= '0;
         r_frame_done <= 1'b0;
         r_drop_err   <= 1'b0;
      end else begin
         r_hold_en    <= 1'b0;
         r_lb_wr_en   <= 1'b0;
         r_out_en     <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.valid_in) r_drop_err <= 1'b1;
               if (bus.start) begin
                  r_state    <= S_RUN;
                  r_busy     <= 1'b1;
                  r_col      <= '0;
                  r_row      <= '0;
                  // A beat arriving with start is still a stray beat.
                  r_drop_err <= bus.valid_in;
               end
            end
            S_RUN: begin
               if (bus.valid_in) begin
                  // Even column: first half of a window row goes to hold.
                  // Odd column, even row: horizontal max goes to line buffer.
                  // Odd column, odd row: window complete, emit.
                  r_hold_en  <= ~r_col[0];
                  r_lb_wr_en <= r_col[0] & ~r_row[0];
                  r_out_en   <= r_col[0] & r_row[0];
                  r_lb_addr  <= w_pair_col;
                  if (r_col[0] && r_row[0]) begin
                     r_out_row <= w_pair_row;
                     r_out_col <= w_pair_col;
                  end
                  if (r_col == LAST_COL) begin
                     r_col <= '0;
                     if (r_row == LAST_ROW) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                     end else begin
                        r_row <= r_row + RW'(1);
                     end
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            S_DONE: begin
               if (bus.valid_in) r_drop_err <= 1'b1;
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = r_busy;
   assign bus.hold_en    = r_hold_en;
   assign bus.lb_wr_en   = r_lb_wr_en;
   assign bus.out_en     = r_out_en;
   assign bus.lb_addr    = r_lb_addr;
   assign bus.out_row    = r_out_row;
   assign bus.out_col    = r_out_col;
   assign bus.frame_done = r_frame_done;
   assign bus.drop_err   = r_drop_err;
endmodule

// File: tb/tb_relu_pool_ctrl.sv
// Bench for relu_pool_ctrl: a 4x4 instance for the directed/random sequences
// and a 24x24 instance for the default-size frame. Expected strobes come from
// a beat-count model: beat k of a frame sits at row k/W, col k%W.
module tb_relu_pool_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   relu_pool_if #(.IN_W(4),  .IN_H(4))  bus4 ();
   relu_pool_if #(.IN_W(24), .IN_H(24)) bus24 ();

   relu_pool_ctrl #(.CONV_BIT(12), .IN_W(4), .IN_H(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   relu_pool_ctrl #(.CONV_BIT(12), .IN_W(24), .IN_H(24)) dut24 (
      .clk (clk),
      .rst (rst),
      .bus (bus24)
   );

   localparam int P_IDLE = 0;
   localparam int P_RUN  = 1;
   localparam int P_DONE = 2;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state per instance (0: 4x4, 1: 24x24).
   int m_phase [2];
   int m_k     [2];
   bit m_drop  [2];

   int out_cnt24  = 0;
   int max_addr24 = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input int sel,
                                input logic e_busy, input logic e_hold, input logic e_lbwr,
                                input logic e_out, input logic e_fd, input logic e_drop,
                                input int e_addr, input int e_orow, input int e_ocol);
      logic [31:0] o_busy, o_hold, o_lbwr, o_out, o_fd, o_drop, o_addr, o_orow, o_ocol;
      if (sel == 0) begin
         o_busy = 32'(bus4.busy);      o_hold = 32'(bus4.hold_en);
         o_lbwr = 32'(bus4.lb_wr_en);  o_out  = 32'(bus4.out_en);
         o_fd   = 32'(bus4.frame_done); o_drop = 32'(bus4.drop_err);
         o_addr = 32'(bus4.lb_addr);   o_orow = 32'(bus4.out_row);
         o_ocol = 32'(bus4.out_col);
      end else begin
         o_busy = 32'(bus24.busy);     o_hold = 32'(bus24.hold_en);
         o_lbwr = 32'(bus24.lb_wr_en); o_out  = 32'(bus24.out_en);
         o_fd   = 32'(bus24.frame_done); o_drop = 32'(bus24.drop_err);
         o_addr = 32'(bus24.lb_addr);  o_orow = 32'(bus24.out_row);
         o_ocol = 32'(bus24.out_col);
         if (o_out == 32'd1) out_cnt24++;
         if ((o_hold | o_lbwr | o_out) == 32'd1 && int'(o_addr) > max_addr24)
            max_addr24 = int'(o_addr);
      end
      check("busy",       o_busy, 32'(e_busy));
      check("hold_en",    o_hold, 32'(e_hold));
      check("lb_wr_en",   o_lbwr, 32'(e_lbwr));
      check("out_en",     o_out,  32'(e_out));
      check("frame_done", o_fd,   32'(e_fd));
      check("drop_err",   o_drop, 32'(e_drop));
      if (e_hold || e_lbwr || e_out) check("lb_addr", o_addr, 32'(e_addr));
      if (e_out) begin
         check("out_row", o_orow, 32'(e_orow));
         check("out_col", o_ocol, 32'(e_ocol));
      end
   endtask

   // One clock: drive inputs on the selected instance, predict, then check.
   task automatic step(input int sel, input bit st, input bit v);
      int W, H, r, c, oth;
      logic e_hold, e_lbwr, e_out, e_fd;
      int e_addr, e_orow, e_ocol;
      W = (sel == 0) ? 4 : 24;
      H = W;
      oth = 1 - sel;
      e_hold = 1'b0; e_lbwr = 1'b0; e_out = 1'b0; e_fd = 1'b0;
      e_addr = 0; e_orow = 0; e_ocol = 0;

      bus4.start     = (sel == 0) ? st : 1'b0;
      bus4.valid_in  = (sel == 0) ? v  : 1'b0;
      bus24.start    = (sel == 1) ? st : 1'b0;
      bus24.valid_in = (sel == 1) ? v  : 1'b0;

      if (m_phase[sel] == P_RUN) begin
         if (v) begin
            r = m_k[sel] / W;
            c = m_k[sel] % W;
            e_hold = (c % 2 == 0);
            e_lbwr = (r % 2 == 0) && (c % 2 == 1);
            e_out  = (r % 2 == 1) && (c % 2 == 1);
            e_addr = c / 2;
            e_orow = r / 2;
            e_ocol = c / 2;
            m_k[sel]++;
            if (m_k[sel] == W * H) begin
               e_fd = 1'b1;
               m_phase[sel] = P_DONE;
            end
         end
      end else if (m_phase[sel] == P_IDLE) begin
         if (v) m_drop[sel] = 1'b1;
         if (st) begin
            m_phase[sel] = P_RUN;
            m_k[sel]     = 0;
            m_drop[sel]  = v;
         end
      end else begin
         if (v) m_drop[sel] = 1'b1;
         m_phase[sel] = P_IDLE;
      end
      if (m_phase[oth] == P_DONE) m_phase[oth] = P_IDLE;

      @(posedge clk);
      #1;
      check_outputs(sel, m_phase[sel] != P_IDLE, e_hold, e_lbwr, e_out, e_fd,
                    m_drop[sel], e_addr, e_orow, e_ocol);
   endtask

   task automatic do_reset(input bit v4);
      rst = 1'b1;
      bus4.start = 1'b0;  bus4.valid_in = v4;
      bus24.start = 1'b0; bus24.valid_in = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus4.valid_in = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_phase[d] = P_IDLE;
         m_k[d]     = 0;
         m_drop[d]  = 1'b0;
      end
      check_outputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_lb_addr", 32'(bus4.lb_addr), 32'd0);
      check("rst_out_row", 32'(bus4.out_row), 32'd0);
      check("rst_out_col", 32'(bus4.out_col), 32'd0);
      check("rst_busy24",  32'(bus24.busy),   32'd0);
   endtask

   task automatic full_frame4();
      step(0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) step(0, 1'b0, 1'b1);
      step(0, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_phase[d] = P_IDLE;
         m_k[d]     = 0;
         m_drop[d]  = 1'b0;
      end
      bus4.start = 1'b0;  bus4.valid_in = 1'b0;
      bus24.start = 1'b0; bus24.valid_in = 1'b0;

      // Reset state.
      do_reset(1'b0);

      // Full back-to-back frame.
      full_frame4();

      // Gapped frame: valid toggling 1,0,1,0.
      step(0, 1'b1, 1'b0);
      for (int i = 0; i < 32; i++) step(0, 1'b0, (i % 2) == 0);
      step(0, 1'b0, 1'b0);

      // Randomly gapped frame.
      step(0, 1'b1, 1'b0);
      for (int i = 0; i < 400 && m_phase[0] == P_RUN; i++) step(0, 1'b0, 1'($urandom % 2));
      check("rand_frame_finished", 32'(m_phase[0] != P_RUN), 32'd1);
      step(0, 1'b0, 1'b0);

      // Stray beats: idle, with start, in DONE; a later start clears the flag.
      step(0, 1'b0, 1'b1);
      step(0, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) step(0, 1'b0, 1'b1);
      step(0, 1'b0, 1'b1);
      step(0, 1'b0, 1'b0);
      step(0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) step(0, 1'b0, 1'b1);
      step(0, 1'b0, 1'b0);

      // Mid-frame reset at beat 6, then a clean frame.
      step(0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(0, 1'b0, 1'b1);
      do_reset(1'b1);
      full_frame4();

      // start during RUN at beat 8 has no effect.
      step(0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(0, 1'b0, 1'b1);
      step(0, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) step(0, 1'b0, 1'b1);
      step(0, 1'b0, 1'b0);

      // Random start/valid traffic, including back-to-back frames.
      for (int i = 0; i < 300; i++) step(0, 1'(($urandom % 6) == 0), 1'(($urandom % 4) != 0));
      for (int i = 0; i < 20; i++) step(0, 1'b0, 1'b0);

      // Default-size 24x24 frame with random gaps.
      step(1, 1'b1, 1'b0);
      for (int i = 0; i < 2000 && m_phase[1] == P_RUN; i++) step(1, 1'b0, 1'(($urandom % 4) != 0));
      check("frame24_finished", 32'(m_phase[1] != P_RUN), 32'd1);
      step(1, 1'b0, 1'b0);
      check("out_en_count24", 32'(out_cnt24), 32'd144);
      check("lb_addr_max24_le_11", 32'(max_addr24 <= 11), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
